ctrl_pipe: RTL and testbench

- Consumer end of the main control decoder. Takes the ID-stage control bundle and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Raises load-use/RAW hazard stalls, resolves beq/bne in MEM, and issues flush/pc_src to the fetch side.
- Sits between the main control decoder, the register file, the ALU and the PC mux of the 5-stage MIPS core.

---
 rtl/ctrl_pipe.sv | 151 +++++++++++++++
 tb/tb_ctrl_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// Control-side pipeline of the 5-stage core: ID/EX, EX/MEM, MEM/WB control registers, hazard stall and branch flush.
// Define CTRL_PIPE_FORWARD_EN when operand forwarding exists downstream (stall only on load-use).
module ctrl_pipe #(
  parameter int REG_AW = 5,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_bne,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_zero,
  output logic              ex_RegDest,
  output logic              ex_ALUSrc,
  output logic [2:0]        ex_ALUOp,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic              wb_RegWrite,
  output logic              wb_MemtoReg,
  output logic [REG_AW-1:0] wb_dst,
  output logic              stall,
  output logic              flush,
  output logic              pc_src
);

  localparam int B_REGDEST  = 0;
  localparam int B_BRANCH   = 1;
  localparam int B_MEMREAD  = 2;
  localparam int B_MEMTOREG = 3;
  localparam int B_MEMWRITE = 4;
  localparam int B_ALUSRC   = 5;
  localparam int B_REGWRITE = 6;

  logic [CTRL_W-1:0] ex_ctrl_reg;
  logic [REG_AW-1:0] ex_dst_reg;
  logic              ex_bne_reg;

  logic              mem_regwrite_reg;
  logic              mem_memtoreg_reg;
  logic              mem_memread_reg;
  logic              mem_memwrite_reg;
  logic              mem_branch_reg;
  logic              mem_bne_reg;
  logic              mem_zero_reg;
  logic [REG_AW-1:0] mem_dst_reg;

  logic              wb_regwrite_reg;
  logic              wb_memtoreg_reg;
  logic [REG_AW-1:0] wb_dst_reg;

  logic              rt_used;
  logic              hazard;
  logic              id_take;
  logic [1:0]        stage_match;
  logic [1:0]        stage_wr;
  logic [REG_AW-1:0] stage_dst [2];

  assign pc_src = mem_branch_reg & (mem_zero_reg ^ mem_bne_reg);
  assign flush  = pc_src;

  // Immediate-ALU instructions ignore rt unless they store it.
  assign rt_used = ~id_ctrl[B_ALUSRC] | id_ctrl[B_MEMWRITE];

  assign stage_wr     = {mem_regwrite_reg, ex_ctrl_reg[B_REGWRITE]};
  assign stage_dst[0] = ex_dst_reg;
  assign stage_dst[1] = mem_dst_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_match
      assign stage_match[gi] = stage_wr[gi] && (stage_dst[gi] != '0) &&
                               ((stage_dst[gi] == id_rs) || (rt_used && (stage_dst[gi] == id_rt)));
    end
  endgenerate

`ifdef CTRL_PIPE_FORWARD_EN
  assign hazard = stage_match[0] & ex_ctrl_reg[B_MEMREAD];
`else
  // WB needs no stall: the register file writes before it is read in the same cycle.
  assign hazard = stage_match[0] | stage_match[1];
`endif

  assign stall   = id_valid & hazard & ~pc_src;
  assign id_take = id_valid & ~stall & ~pc_src;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl_reg      <= '0;
      ex_dst_reg       <= '0;
      ex_bne_reg       <= 1'b0;
      mem_regwrite_reg <= 1'b0;
      mem_memtoreg_reg <= 1'b0;
      mem_memread_reg  <= 1'b0;
      mem_memwrite_reg <= 1'b0;
      mem_branch_reg   <= 1'b0;
      mem_bne_reg      <= 1'b0;
      mem_zero_reg     <= 1'b0;
      mem_dst_reg      <= '0;
      wb_regwrite_reg  <= 1'b0;
      wb_memtoreg_reg  <= 1'b0;
      wb_dst_reg       <= '0;
    end else begin
      if (id_take) begin
        ex_ctrl_reg <= id_ctrl;
        ex_bne_reg  <= id_bne;
        ex_dst_reg  <= id_ctrl[B_REGDEST] ? id_rd : id_rt;
      end else begin
        ex_ctrl_reg <= '0;
        ex_bne_reg  <= 1'b0;
        ex_dst_reg  <= '0;
      end

      if (pc_src) begin
        mem_regwrite_reg <= 1'b0;
        mem_memtoreg_reg <= 1'b0;
        mem_memread_reg  <= 1'b0;
        mem_memwrite_reg <= 1'b0;
        mem_branch_reg   <= 1'b0;
        mem_bne_reg      <= 1'b0;
        mem_zero_reg     <= 1'b0;
        mem_dst_reg      <= '0;
      end else begin
        mem_regwrite_reg <= ex_ctrl_reg[B_REGWRITE];
        mem_memtoreg_reg <= ex_ctrl_reg[B_MEMTOREG];
        mem_memread_reg  <= ex_ctrl_reg[B_MEMREAD];
        mem_memwrite_reg <= ex_ctrl_reg[B_MEMWRITE];
        mem_branch_reg   <= ex_ctrl_reg[B_BRANCH];
        mem_bne_reg      <= ex_bne_reg;
        mem_zero_reg     <= ex_zero;
        mem_dst_reg      <= ex_dst_reg;
      end

      wb_regwrite_reg <= mem_regwrite_reg;
      wb_memtoreg_reg <= mem_memtoreg_reg;
      wb_dst_reg      <= mem_dst_reg;
    end
  end

  assign ex_RegDest   = ex_ctrl_reg[B_REGDEST];
  assign ex_ALUSrc    = ex_ctrl_reg[B_ALUSRC];
  assign ex_ALUOp     = ex_ctrl_reg[CTRL_W-1:CTRL_W-3];
  assign mem_MemRead  = mem_memread_reg;
  assign mem_MemWrite = mem_memwrite_reg;
  assign wb_RegWrite  = wb_regwrite_reg;
  assign wb_MemtoReg  = wb_memtoreg_reg;
  assign wb_dst       = wb_dst_reg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus randomized traffic against an instruction-level model.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [9:0] id_ctrl;
  logic       id_bne;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_zero;
  logic       ex_RegDest, ex_ALUSrc;
  logic [2:0] ex_ALUOp;
  logic       mem_MemRead, mem_MemWrite;
  logic       wb_RegWrite, wb_MemtoReg;
  logic [4:0] wb_dst;
  logic       stall, flush, pc_src;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_bne(id_bne),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .ex_RegDest(ex_RegDest), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_dst(wb_dst),
    .stall(stall), .flush(flush), .pc_src(pc_src)
  );

  localparam logic [9:0] C_ADD  = 10'b010_1000001;
  localparam logic [9:0] C_SUB  = 10'b110_1000001;
  localparam logic [9:0] C_LW   = 10'b000_1101100;
  localparam logic [9:0] C_SW   = 10'b000_0110000;
  localparam logic [9:0] C_BEQ  = 10'b001_0000010;
  localparam logic [9:0] C_ADDI = 10'b000_1100000;

`ifdef CTRL_PIPE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Instruction-level view of what sits in a stage.
  typedef struct packed {
    bit       wr, mr, mw, m2r, br, rdst, asrc;
    bit [2:0] op;
    bit [4:0] dst;
    bit       bne, zero;
  } instr_t;

  instr_t m_ex, m_mem, m_wb;

  function automatic instr_t decode(input logic [9:0] c, input logic b, input logic [4:0] rt, input logic [4:0] rd);
    instr_t r;
    r.op   = c[9:7];
    r.wr   = c[6];
    r.asrc = c[5];
    r.mw   = c[4];
    r.m2r  = c[3];
    r.mr   = c[2];
    r.br   = c[1];
    r.rdst = c[0];
    r.dst  = c[0] ? rd : rt;
    r.bne  = b;
    r.zero = 1'b0;
    return r;
  endfunction

  function automatic bit writes_operand(input instr_t s, input logic [4:0] rs, input logic [4:0] rt, input bit uses_rt);
    return s.wr && (s.dst != 0) && ((s.dst == rs) || (uses_rt && (s.dst == rt)));
  endfunction

  task automatic set_in(input logic v, input logic [9:0] c, input logic b,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic z);
    id_valid = v; id_ctrl = c; id_bne = b; id_rs = rs; id_rt = rt; id_rd = rd; ex_zero = z;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 10'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    reset = 1'b1;
    set_in(1'b1, C_ADD, 1'b0, 5'd1, 5'd1, 5'd8, 1'b0);
    repeat (2) tick();
    outs = {ex_RegDest, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg, wb_dst, stall, flush, pc_src};
    n_total++;
    if (outs !== 18'd0) $display("FAIL reset_outputs got=%h want=0", outs); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (ex_ALUOp !== 3'b000) $display("FAIL reset_hold ex_ALUOp got=%b want=000", ex_ALUOp); else n_pass++;
    tick();
    n_total++;
    if ({ex_ALUOp, ex_RegDest} !== 4'b0101) $display("FAIL reset_first_ex got=%b want=0101", {ex_ALUOp, ex_RegDest}); else n_pass++;
    $display("reset: outs=%h first ex_ALUOp=%b", outs, ex_ALUOp);
  endtask

  task automatic test_rtype();
    idle(3);
    set_in(1'b1, C_ADD, 1'b0, 5'd1, 5'd2, 5'd8, 1'b0);
    n_total++;
    if (stall !== 1'b0) $display("FAIL rtype_nostall got=%b want=0", stall); else n_pass++;
    tick();
    set_in(1'b0, 10'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    n_total++;
    if ({ex_ALUOp, ex_ALUSrc, ex_RegDest} !== 5'b01001) $display("FAIL rtype_ex got=%b want=01001", {ex_ALUOp, ex_ALUSrc, ex_RegDest}); else n_pass++;
    tick();
    n_total++;
    if ({mem_MemRead, mem_MemWrite} !== 2'b00) $display("FAIL rtype_mem got=%b want=00", {mem_MemRead, mem_MemWrite}); else n_pass++;
    tick();
    n_total++;
    if ({wb_RegWrite, wb_MemtoReg, wb_dst} !== {2'b10, 5'd8}) $display("FAIL rtype_wb got=%b/%b/%0d want=1/0/8", wb_RegWrite, wb_MemtoReg, wb_dst); else n_pass++;
    $display("rtype: wb_RegWrite=%b wb_dst=%0d", wb_RegWrite, wb_dst);
  endtask

  task automatic test_load_use();
    int cnt;
    idle(3);
    set_in(1'b1, C_LW, 1'b0, 5'd1, 5'd9, 5'd3, 1'b0);
    tick();
    set_in(1'b1, C_ADD, 1'b0, 5'd9, 5'd3, 5'd4, 1'b0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (!stall) break;
      cnt++;
      tick();
      if (cnt == 1) begin
        n_total++;
        if ({ex_ALUOp, ex_RegDest} !== 4'b0000) $display("FAIL load_use_bubble got=%b want=0000", {ex_ALUOp, ex_RegDest}); else n_pass++;
      end
    end
    n_total++;
    if (cnt !== (FWD ? 1 : 2)) $display("FAIL load_use_stall_cycles got=%0d want=%0d", cnt, (FWD ? 1 : 2)); else n_pass++;
    tick();
    set_in(1'b0, 10'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    n_total++;
    if ({ex_ALUOp, ex_RegDest} !== 4'b0101) $display("FAIL load_use_add_in_ex got=%b want=0101", {ex_ALUOp, ex_RegDest}); else n_pass++;
    $display("load_use: stall cycles=%0d", cnt);

    idle(3);
    set_in(1'b1, C_LW, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    set_in(1'b1, C_ADD, 1'b0, 5'd0, 5'd0, 5'd4, 1'b0);
    n_total++;
    if (stall !== 1'b0) $display("FAIL load_use_r0 got=%b want=0", stall); else n_pass++;
    tick();
    n_total++;
    if (stall !== 1'b0) $display("FAIL load_use_r0_mem got=%b want=0", stall); else n_pass++;
    $display("load_use_r0: stall=%b", stall);
  endtask

  task automatic test_alu_use();
    int cnt;
    idle(3);
    set_in(1'b1, C_ADD, 1'b0, 5'd1, 5'd2, 5'd10, 1'b0);
    tick();
    set_in(1'b1, C_SUB, 1'b0, 5'd3, 5'd10, 5'd11, 1'b0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (!stall) break;
      cnt++;
      tick();
    end
    n_total++;
    if (cnt !== (FWD ? 0 : 2)) $display("FAIL alu_use_stall_cycles got=%0d want=%0d", cnt, (FWD ? 0 : 2)); else n_pass++;
    tick();
    set_in(1'b0, 10'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    n_total++;
    if (ex_ALUOp !== 3'b110) $display("FAIL alu_use_sub_in_ex got=%b want=110", ex_ALUOp); else n_pass++;
    $display("alu_use: stall cycles=%0d", cnt);
  endtask

  task automatic test_branch();
    idle(3);
    set_in(1'b1, C_BEQ, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    set_in(1'b1, C_LW, 1'b0, 5'd13, 5'd12, 5'd0, 1'b1);
    n_total++;
    if (pc_src !== 1'b0) $display("FAIL branch_early got=%b want=0", pc_src); else n_pass++;
    tick();
    set_in(1'b1, C_ADD, 1'b0, 5'd14, 5'd15, 5'd16, 1'b0);
    n_total++;
    if ({pc_src, flush, stall} !== 3'b110) $display("FAIL branch_taken got=%b want=110", {pc_src, flush, stall}); else n_pass++;
    tick();
    set_in(1'b0, 10'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    n_total++;
    if ({ex_ALUOp, ex_RegDest, mem_MemRead, pc_src} !== 6'd0) $display("FAIL branch_squash got=%b want=000000", {ex_ALUOp, ex_RegDest, mem_MemRead, pc_src}); else n_pass++;
    tick();
    n_total++;
    if (wb_RegWrite !== 1'b0) $display("FAIL branch_wb_bubble got=%b want=0", wb_RegWrite); else n_pass++;
    $display("branch: beq taken squashed younger ops");
  endtask

  task automatic test_bne();
    logic [2:0] tbl [3];
    logic [2:0] row;
    tbl[0] = 3'b000; tbl[1] = 3'b110; tbl[2] = 3'b101;
    for (int k = 0; k < 3; k++) begin
      row = tbl[k];
      idle(3);
      set_in(1'b1, C_BEQ, row[2], 5'd1, 5'd2, 5'd0, 1'b0);
      tick();
      set_in(1'b0, 10'd0, 1'b0, 5'd0, 5'd0, 5'd0, row[1]);
      tick();
      set_in(1'b0, 10'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      n_total++;
      if ({pc_src, flush} !== {row[0], row[0]}) $display("FAIL bne_case%0d got=%b%b want=%b%b", k, pc_src, flush, row[0], row[0]); else n_pass++;
      $display("branch bne=%b zero=%b: pc_src=%b", row[2], row[1], pc_src);
    end
  endtask

  task automatic test_stall_flush();
    idle(3);
    set_in(1'b1, C_BEQ, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    set_in(1'b1, C_LW, 1'b0, 5'd1, 5'd9, 5'd0, 1'b1);
    tick();
    set_in(1'b1, C_ADD, 1'b0, 5'd9, 5'd3, 5'd4, 1'b0);
    n_total++;
    if ({stall, pc_src} !== 2'b01) $display("FAIL stall_vs_flush got=%b want=01", {stall, pc_src}); else n_pass++;
    tick();
    set_in(1'b0, 10'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    n_total++;
    if ({ex_ALUOp, ex_RegDest, mem_MemRead} !== 5'd0) $display("FAIL stall_vs_flush_bubbles got=%b want=00000", {ex_ALUOp, ex_RegDest, mem_MemRead}); else n_pass++;
    $display("stall_vs_flush: stall suppressed, pipeline squashed");
  endtask

  task automatic test_reset_mid();
    idle(3);
    set_in(1'b1, C_LW, 1'b0, 5'd1, 5'd9, 5'd0, 1'b0);
    tick();
    set_in(1'b1, C_ADD, 1'b0, 5'd9, 5'd3, 5'd4, 1'b0);
    reset = 1'b1;
    tick();
    n_total++;
    if ({ex_ALUOp, ex_RegDest, mem_MemRead, wb_RegWrite, wb_dst, stall} !== 11'd0)
      $display("FAIL reset_mid got=%b want=0", {ex_ALUOp, ex_RegDest, mem_MemRead, wb_RegWrite, wb_dst, stall});
    else n_pass++;
    reset = 1'b0;
    $display("reset_mid: pipeline cleared");
  endtask

  task automatic test_random();
    logic [9:0]  tbl [6];
    logic [13:0] got_reg, exp_reg;
    logic [2:0]  got_cmb, exp_cmb;
    logic        v, b, z, exp_pc, exp_stall, haz, uses_rt;
    logic [9:0]  c;
    logic [4:0]  rs, rt, rd;
    instr_t      bubble;
    int          errs;
    tbl[0] = C_ADD; tbl[1] = C_SUB; tbl[2] = C_LW; tbl[3] = C_SW; tbl[4] = C_BEQ; tbl[5] = C_ADDI;
    bubble = '0;
    errs = 0;
    idle(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_ex = bubble; m_mem = bubble; m_wb = bubble;
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      c  = tbl[$urandom_range(0, 5)];
      b  = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      set_in(v, c, b, rs, rt, rd, z);

      uses_rt   = !c[5] || c[4];
      exp_pc    = m_mem.br && (m_mem.zero != m_mem.bne);
      haz       = FWD ? (m_ex.mr && writes_operand(m_ex, rs, rt, uses_rt))
                      : (writes_operand(m_ex, rs, rt, uses_rt) || writes_operand(m_mem, rs, rt, uses_rt));
      exp_stall = v && haz && !exp_pc;

      exp_cmb = {exp_stall, exp_pc, exp_pc};
      got_cmb = {stall, pc_src, flush};
      exp_reg = {m_ex.rdst, m_ex.asrc, m_ex.op, m_mem.mr, m_mem.mw, m_wb.wr, m_wb.m2r, m_wb.dst};
      got_reg = {ex_RegDest, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg, wb_dst};
      n_total++;
      if (got_cmb !== exp_cmb) begin
        errs++;
        $display("FAIL random_comb cyc=%0d stall/pc/flush got=%b want=%b", n, got_cmb, exp_cmb);
      end else n_pass++;
      n_total++;
      if (got_reg !== exp_reg) begin
        errs++;
        $display("FAIL random_regs cyc=%0d got=%b want=%b", n, got_reg, exp_reg);
      end else n_pass++;

      m_wb = m_mem;
      if (exp_pc) m_mem = bubble;
      else begin
        m_mem = m_ex;
        m_mem.zero = z;
      end
      m_ex = (v && !exp_stall && !exp_pc) ? decode(c, b, rt, rd) : bubble;
      tick();
    end
    $display("random: 400 cycles, %0d mismatching checks", errs);
  endtask

  initial begin
    reset = 1'b1;
    id_valid = 1'b0; id_ctrl = '0; id_bne = 1'b0;
    id_rs = '0; id_rt = '0; id_rd = '0; ex_zero = 1'b0;
    test_reset();
    test_rtype();
    test_load_use();
    test_alu_use();
    test_branch();
    test_bne();
    test_stall_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
